// File: rtl/hatch_pkg.sv
// hatch_pkg: shared FSM state encoding and frame constants for hatch_ctrl
package hatch_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARM    = 3'd1,
    S_COLD    = 3'd2,
    S_HATCHED = 3'd3,
    S_FAILED  = 3'd4
  } state_t;
  localparam logic [3:0] FRAME_EGG = 4'd0;
  localparam int LAST_FRAME = 11;
endpackage

// File: rtl/hatch_ctrl_step_tick.sv
// step_tick: free-running 0..STEP_TICKS-1 counter; ports clk, rst (async), clr (sync clear) -> pulse on the wrap cycle
module step_tick #(
  parameter int STEP_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic pulse
);
  localparam int W = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
  logic [W-1:0] r_cnt;
  logic w_wrap;
  assign w_wrap = r_cnt == W'(STEP_TICKS - 1);
  assign pulse = w_wrap;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (clr || w_wrap) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/hatch_ctrl.sv
// hatch_ctrl: egg incubation FSM; in clk, rst (async), st, temp; out num (frame), temp_led, done, fail, state (debug)
module hatch_ctrl #(
  parameter int STEP_TICKS = 1000,
  parameter int COLD_STEPS = 5,
  parameter int LAST_FRAME = hatch_pkg::LAST_FRAME
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       temp,
  output logic [3:0] num,
  output logic       temp_led,
  output logic       done,
  output logic       fail,
  output logic [2:0] state
);
  import hatch_pkg::*;
  localparam int CW = $clog2(COLD_STEPS + 1);
  state_t r_state;
  logic [3:0] r_num;
  logic [CW-1:0] r_cold;
  logic r_led, r_done, r_fail;
  logic w_pulse, w_clr;
  logic [3:0] w_num_nxt;
  logic [CW-1:0] w_cold_nxt;
  // tick counter idles at zero so a fresh run always starts a full step
  assign w_clr = r_state == S_IDLE || !st;
  assign w_num_nxt = r_num + 4'd1;
  assign w_cold_nxt = r_cold == CW'(COLD_STEPS) ? r_cold : r_cold + 1'b1;
  step_tick #(.STEP_TICKS(STEP_TICKS)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(w_clr),
    .pulse(w_pulse)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_num <= FRAME_EGG;
      r_cold <= '0;
      r_led <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else if (!st) begin
      r_state <= S_IDLE;
      r_num <= FRAME_EGG;
      r_cold <= '0;
      r_led <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_led <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= temp ? S_WARM : S_COLD;
          r_cold <= '0;
          r_led <= temp;
        end
        S_WARM: begin
          r_led <= temp;
          if (!temp) r_state <= S_COLD;
          else if (w_pulse) begin
            r_num <= w_num_nxt;
            if (w_num_nxt == 4'(LAST_FRAME)) begin
              r_state <= S_HATCHED;
              r_done <= 1'b1;
              r_led <= 1'b0;
            end
          end
        end
        S_COLD: begin
          if (temp) begin
            r_state <= S_WARM;
            r_cold <= '0;
            r_led <= 1'b1;
          end else if (w_pulse) begin
            r_cold <= w_cold_nxt;
            if (w_cold_nxt == CW'(COLD_STEPS)) begin
              r_state <= S_FAILED;
              r_num <= FRAME_EGG;
              r_fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign num = r_num;
  assign temp_led = r_led;
  assign done = r_done;
  assign fail = r_fail;
  assign state = r_state;
endmodule

// File: tb/tb_hatch_ctrl.sv
// tb_hatch_ctrl: directed scenarios plus randomized run checked against a behavioural model of hatch_ctrl
module tb_hatch_ctrl;
  import hatch_pkg::*;
  localparam int ST = 4, CS = 2, LF = 11;
  localparam int M_IDLE = 0, M_WARM = 1, M_COLD = 2, M_HATCH = 3, M_FAIL = 4;
  logic clk = 0, rst = 1, st = 0, temp = 0;
  logic [3:0] num;
  logic temp_led, done, fail;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0;
  int m_ph = M_IDLE, m_frame = 0, m_cold = 0, m_age = 0, m_led = 0;
  hatch_ctrl #(.STEP_TICKS(ST), .COLD_STEPS(CS), .LAST_FRAME(LF)) dut (
    .clk(clk), .rst(rst), .st(st), .temp(temp), .num(num),
    .temp_led(temp_led), .done(done), .fail(fail), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic int ph_code(input int p);
    case (p)
      M_WARM:  return int'(S_WARM);
      M_COLD:  return int'(S_COLD);
      M_HATCH: return int'(S_HATCHED);
      M_FAIL:  return int'(S_FAILED);
      default: return int'(S_IDLE);
    endcase
  endfunction
  // model: m_age counts cycles since the run started; a step lands every ST-th cycle
  task automatic model_step();
    bit pulse;
    pulse = m_ph != M_IDLE && (m_age % ST) == ST - 1;
    if (!st) begin
      m_ph = M_IDLE; m_frame = 0; m_cold = 0; m_age = 0;
    end else begin
      m_age++;
      case (m_ph)
        M_IDLE: begin m_ph = temp ? M_WARM : M_COLD; m_age = 0; m_cold = 0; end
        M_WARM:
          if (!temp) m_ph = M_COLD;
          else if (pulse) begin
            m_frame++;
            if (m_frame == LF) m_ph = M_HATCH;
          end
        M_COLD:
          if (temp) begin m_ph = M_WARM; m_cold = 0; end
          else if (pulse) begin
            if (m_cold < CS) m_cold++;
            if (m_cold == CS) begin m_ph = M_FAIL; m_frame = 0; end
          end
        default: ;
      endcase
    end
    m_led = (m_ph == M_WARM || m_ph == M_COLD) ? int'(temp) : 0;
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = M_IDLE; m_frame = 0; m_cold = 0; m_age = 0; m_led = 0;
    end else model_step();
    #1;
    chk("m_num", num, m_frame);
    chk("m_state", state, ph_code(m_ph));
    chk("m_done", done, m_ph == M_HATCH);
    chk("m_fail", fail, m_ph == M_FAIL);
    chk("m_temp_led", temp_led, m_led);
  end
  task automatic wait_num(input int n, output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (num != 4'(n) && c < 300);
    chk("reach_num", num, n);
  endtask
  task automatic wait_flag(input bit want_fail, output int c);
    c = 0;
    do begin @(negedge clk); c++; end while ((want_fail ? fail : done) != 1'b1 && c < 300);
    chk(want_fail ? "reach_fail" : "reach_done", want_fail ? fail : done, 1);
  endtask
  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_num", num, 0);
    chk("rst_state", state, S_IDLE);
    chk("rst_done", done, 0);
    rst = 0;
    @(negedge clk);
    st = 1; temp = 1;
    wait_flag(0, c);
    chk("hatch_cycles", c, 45);
    chk("hatch_num", num, 11);
    chk("hatch_state", state, S_HATCHED);
    temp = 0;
    repeat (5) begin
      @(negedge clk);
      chk("hatch_hold_num", num, 11);
      chk("hatch_hold_done", done, 1);
    end
    st = 0;
    @(negedge clk);
    chk("stop_state", state, S_IDLE);
    chk("stop_done", done, 0);
    st = 1; temp = 1;
    wait_num(3, c);
    chk("to3_cycles", c, 13);
    temp = 0;
    repeat (4) begin
      @(negedge clk);
      chk("cold_num", num, 3);
      chk("cold_led", temp_led, 0);
      chk("cold_state", state, S_COLD);
      chk("cold_fail", fail, 0);
    end
    temp = 1;
    wait_num(4, c);
    chk("resume_cycles", c, 4);
    st = 0;
    @(negedge clk);
    st = 1; temp = 1;
    wait_num(5, c);
    chk("to5_cycles", c, 21);
    temp = 0;
    wait_flag(1, c);
    chk("fail_cycles", c, 8);
    chk("fail_num", num, 0);
    chk("fail_state", state, S_FAILED);
    temp = 1;
    repeat (5) begin
      @(negedge clk);
      chk("fail_hold", fail, 1);
      chk("fail_hold_state", state, S_FAILED);
    end
    st = 0;
    @(negedge clk);
    st = 1; temp = 1;
    wait_num(6, c);
    repeat (3) @(negedge clk);
    chk("pre_stop_num", num, 6);
    st = 0;
    @(negedge clk);
    chk("stop_pulse_num", num, 0);
    chk("stop_pulse_state", state, S_IDLE);
    st = 1;
    wait_num(8, c);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_num", num, 0);
    chk("async_state", state, S_IDLE);
    chk("async_led", temp_led, 0);
    @(negedge clk);
    rst = 0;
    wait_num(1, c);
    chk("restart_cycles", c, 5);
    st = 0;
    @(negedge clk);
    temp = 0; st = 1;
    @(negedge clk);
    chk("idle_cold_state", state, S_COLD);
    chk("idle_cold_num", num, 0);
    wait_flag(1, c);
    chk("idle_cold_fail_cycles", c, 8);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      st = st ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) temp = ~temp;
    end
    rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
